nco_gen: RTL and testbench

//  Numerically controlled oscillator feeding one NCO input (data0_i/data1_i) of the 2x32->128 DAC packer.

---
 rtl/nco_pkg.sv | 35 +++
 rtl/nco_quarter_rom.sv | 43 ++++
 rtl/nco_gen.sv | 134 +++++++++++++
 tb/tb_nco_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared NCO constants, quadrant encoding and the quarter-wave table generator.
// The quadrant helpers keep the sine/cosine folding rule in one place.
package nco_pkg;

    localparam int NCO_PHASE_W = 32;
    localparam int NCO_POW_W   = 16;
    localparam int NCO_LUT_AW  = 10;
    localparam int NCO_OUT_W   = 16;

    localparam real NCO_PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // Odd quadrants read the table mirrored; the lower half-plane is negated.
    function automatic logic quad_mirror(input quad_e q);
        return (q == QUAD_1) || (q == QUAD_3);
    endfunction

    function automatic logic quad_negate(input quad_e q);
        return (q == QUAD_2) || (q == QUAD_3);
    endfunction

    // Half-LSB phase offset makes L[k] and L[~k] exact mirrors about pi/2.
    function automatic int quarter_sine(input int k, input int aw, input int amp);
        real theta;
        theta = 2.0 * NCO_PI * (real'(k) + 0.5) / real'(4 * (2 ** aw));
        return $rtoi(real'(amp) * $sin(theta) + 0.5);
    endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Quarter-wave sine magnitude table with two registered read ports,
// one for the sine lookup and one for the cosine lookup.
module nco_quarter_rom
    import nco_pkg::*;
#(
    parameter int AW = NCO_LUT_AW,
    parameter int MW = NCO_OUT_W - 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] sin_addr_i,
    input  logic [AW-1:0] cos_addr_i,
    output logic [MW-1:0] sin_mag_o,
    output logic [MW-1:0] cos_mag_o
);

    localparam int DEPTH = 2 ** AW;
    localparam int AMP   = (2 ** MW) - 1;

    logic [MW-1:0] rom [DEPTH];
    logic [MW-1:0] sin_mag_q;
    logic [MW-1:0] cos_mag_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = MW'(quarter_sine(k, AW, AMP));
    end

    // NOTE: the table is a constant, so only the read registers take reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sin_mag_q <= '0;
            cos_mag_q <= '0;
        end else if (rd_en_i) begin
            sin_mag_q <= rom[sin_addr_i];
            cos_mag_q <= rom[cos_addr_i];
        end
    end

    assign sin_mag_o = sin_mag_q;
    assign cos_mag_o = cos_mag_q;

endmodule

// File: rtl/nco_gen.sv
// Numerically controlled oscillator: double-buffered FTW/POW, phase accumulator
// and a 4-stage quarter-wave pipeline producing one {sin, cos} pair per enable.
module nco_gen
    import nco_pkg::*;
#(
    parameter int PHASE_W = NCO_PHASE_W,
    parameter int POW_W   = NCO_POW_W,
    parameter int LUT_AW  = NCO_LUT_AW,
    parameter int OUT_W   = NCO_OUT_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               cfg_wr_i,
    input  logic [PHASE_W-1:0] ftw_i,
    input  logic [POW_W-1:0]   pow_i,
    input  logic               cfg_upd_i,
    input  logic               phase_clr_i,
    output logic [2*OUT_W-1:0] data_o,
    output logic               valid_o
);

    localparam int PH_TOP = 2 + LUT_AW;
    localparam int LAT    = 4;

    logic [PHASE_W-1:0]        ftw_sh_q, ftw_sh_d, ftw_act_q, ftw_act_d;
    logic [POW_W-1:0]          pow_sh_q, pow_sh_d, pow_act_q, pow_act_d;
    logic [PHASE_W-1:0]        acc_q, acc_d;
    logic [PHASE_W-1:0]        ph_full;
    logic [PHASE_W-PH_TOP-1:0] ph_lsb_unused;
    logic [PH_TOP-1:0]         ph_q, ph_d;
    logic [LAT-1:0]            vld_q;

    quad_e                     q_sin, q_cos;
    logic [LUT_AW-1:0]         ph_addr;
    logic [LUT_AW-1:0]         sin_addr_q, sin_addr_d, cos_addr_q, cos_addr_d;
    logic                      sin_neg2_q, sin_neg2_d, cos_neg2_q, cos_neg2_d;
    logic                      sin_neg3_q, cos_neg3_q;
    logic [OUT_W-2:0]          sin_mag, cos_mag;
    logic [OUT_W-1:0]          sin_abs, cos_abs;
    logic [2*OUT_W-1:0]        data_q, data_d;

    always_comb begin
        // Write and update in the same cycle pass the new words straight through.
        ftw_sh_d  = cfg_wr_i  ? ftw_i    : ftw_sh_q;
        pow_sh_d  = cfg_wr_i  ? pow_i    : pow_sh_q;
        ftw_act_d = cfg_upd_i ? ftw_sh_d : ftw_act_q;
        pow_act_d = cfg_upd_i ? pow_sh_d : pow_act_q;

        // NOTE: default first, so every path assigns acc_d and no latch is inferred.
        acc_d = acc_q;
        if (phase_clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ftw_act_q;
        end

        ph_full                  = acc_q + {pow_act_q, {(PHASE_W - POW_W){1'b0}}};
        {ph_d, ph_lsb_unused}    = ph_full;

        q_sin      = quad_e'(ph_q[PH_TOP-1 -: 2]);
        q_cos      = quad_e'(q_sin + 2'd1);
        ph_addr    = ph_q[LUT_AW-1:0];
        sin_addr_d = quad_mirror(q_sin) ? ~ph_addr : ph_addr;
        cos_addr_d = quad_mirror(q_cos) ? ~ph_addr : ph_addr;
        sin_neg2_d = quad_negate(q_sin);
        cos_neg2_d = quad_negate(q_cos);

        // Table magnitudes never exceed 2^(OUT_W-1)-1, so negation cannot overflow.
        sin_abs = {1'b0, sin_mag};
        cos_abs = {1'b0, cos_mag};
        data_d  = {sin_neg3_q ? -sin_abs : sin_abs, cos_neg3_q ? -cos_abs : cos_abs};
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ftw_sh_q   <= '0;
            ftw_act_q  <= '0;
            pow_sh_q   <= '0;
            pow_act_q  <= '0;
            acc_q      <= '0;
            ph_q       <= '0;
            vld_q      <= '0;
            sin_addr_q <= '0;
            cos_addr_q <= '0;
            sin_neg2_q <= 1'b0;
            cos_neg2_q <= 1'b0;
            sin_neg3_q <= 1'b0;
            cos_neg3_q <= 1'b0;
            data_q     <= '0;
        end else begin
            ftw_sh_q  <= ftw_sh_d;
            ftw_act_q <= ftw_act_d;
            pow_sh_q  <= pow_sh_d;
            pow_act_q <= pow_act_d;
            acc_q     <= acc_d;
            vld_q     <= {vld_q[LAT-2:0], en_i};
            if (en_i) begin
                ph_q <= ph_d;
            end
            if (vld_q[0]) begin
                sin_addr_q <= sin_addr_d;
                cos_addr_q <= cos_addr_d;
                sin_neg2_q <= sin_neg2_d;
                cos_neg2_q <= cos_neg2_d;
            end
            if (vld_q[1]) begin
                sin_neg3_q <= sin_neg2_q;
                cos_neg3_q <= cos_neg2_q;
            end
            if (vld_q[2]) begin
                data_q <= data_d;
            end
        end
    end

    nco_quarter_rom #(
        .AW (LUT_AW),
        .MW (OUT_W - 1)
    ) u_rom (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rd_en_i    (vld_q[1]),
        .sin_addr_i (sin_addr_q),
        .cos_addr_i (cos_addr_q),
        .sin_mag_o  (sin_mag),
        .cos_mag_o  (cos_mag)
    );

    assign data_o  = data_q;
    assign valid_o = vld_q[LAT-1];

endmodule

// File: tb/tb_nco_gen.sv
// Scoreboard bench for nco_gen: a floating-point phase/sine model predicts each
// sample when en_i is driven; two instances are checked against it every cycle.
module tb_nco_gen;

    localparam int  HALF = 5;
    localparam real PI   = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        reset, en, cfg_wr, cfg_upd, phase_clr;
    logic [31:0] ftw;
    logic [15:0] pow;
    logic [31:0] data0, data1;
    logic        valid0, valid1;

    always #HALF clk = ~clk;

    nco_gen u_dut0 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .cfg_wr_i(cfg_wr), .ftw_i(ftw),
        .pow_i(pow), .cfg_upd_i(cfg_upd), .phase_clr_i(phase_clr),
        .data_o(data0), .valid_o(valid0)
    );

    nco_gen u_dut1 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .cfg_wr_i(cfg_wr), .ftw_i(ftw),
        .pow_i(pow), .cfg_upd_i(cfg_upd), .phase_clr_i(phase_clr),
        .data_o(data1), .valid_o(valid1)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    bit          mon_exp_v;
    bit          mon_en   = 1'b0;
    logic        rst_smp  = 1'b1;
    logic [31:0] last_exp = '0;
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          cyc      = 0;

    logic [31:0] m_acc, m_fs, m_fa;
    logic [15:0] m_ps, m_pa;
    logic [31:0] quad_tbl [4] = '{32'h7FFF_FFE7, 32'hFFE7_8001, 32'h8001_0019, 32'h0019_7FFF};
    logic [7:0]  en_pat = 8'b1011_1001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    // Full-circle model: top 12 phase bits select the angle, centred in its bin.
    function automatic logic [31:0] model_sample(input logic [31:0] ph);
        real th;
        int  s, c;
        th = 2.0 * PI * (real'(ph[31:20]) + 0.5) / 4096.0;
        s  = rnd(32767.0 * $sin(th));
        c  = rnd(32767.0 * $cos(th));
        return {s[15:0], c[15:0]};
    endfunction

    // Applies the inputs about to be sampled at the next rising edge.
    task automatic model_edge();
        if (reset) begin
            m_acc = '0; m_fs = '0; m_fa = '0; m_ps = '0; m_pa = '0;
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        end else begin
            if (en) sb.push_back('{due: cyc + 4, data: model_sample(m_acc + {m_pa, 16'h0000})});
            if (phase_clr) m_acc = '0;
            else if (en)   m_acc = m_acc + m_fa;
            if (cfg_upd) begin
                m_fa = cfg_wr ? ftw : m_fs;
                m_pa = cfg_wr ? pow : m_ps;
            end
            if (cfg_wr) begin
                m_fs = ftw;
                m_ps = pow;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic commit(input logic [31:0] f, input logic [15:0] p, input logic clr);
        ftw = f; pow = p; cfg_wr = 1'b1; cfg_upd = 1'b1; phase_clr = clr;
        tick();
        cfg_wr = 1'b0; cfg_upd = 1'b0; phase_clr = 1'b0;
    endtask

    always @(posedge clk) rst_smp <= reset;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            if (rst_smp) last_exp = '0;
            if (mon_exp_v) begin
                mon_e    = sb.pop_front();
                last_exp = mon_e.data;
            end
            check("valid0", 32'(valid0), 32'(mon_exp_v));
            check("valid1", 32'(valid1), 32'(mon_exp_v));
            check("data0", data0, last_exp);
            check("data1", data1, last_exp);
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; cfg_wr = 1'b0; cfg_upd = 1'b0; phase_clr = 1'b0;
        ftw = '0; pow = '0;
        tick();
        mon_en = 1'b1;
        tick();

        // DC output with zero FTW/POW
        reset = 1'b0; en = 1'b1;
        run(8);
        check("t1_dc", data0, 32'h0019_7FFF);

        // Quarter-turn steps
        commit(32'h4000_0000, 16'h0000, 1'b1);
        run(5);
        for (int i = 0; i < 8; i++) begin
            check("t2_quad", data0, quad_tbl[i % 4]);
            tick();
        end

        // Phase offset only
        commit(32'h0000_0000, 16'h4000, 1'b1);
        run(6);
        check("t3_pow90", data0, 32'h7FFF_FFE7);
        commit(32'h0000_0000, 16'h8000, 1'b0);
        run(6);
        check("t3_pow180", data0, 32'hFFE7_8001);

        // Shadow write without update, then separate update, then write+update
        commit(32'h0100_0000, 16'h0000, 1'b1);
        run(6);
        ftw = 32'h0280_0000; pow = 16'h0000; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        run(6);
        cfg_upd = 1'b1;
        tick();
        cfg_upd = 1'b0;
        run(6);
        commit(32'h0530_0000, 16'h1234, 1'b0);
        run(6);

        // Enable gaps and mid-run phase clear
        commit(32'h0100_0000, 16'h0000, 1'b0);
        run(4);
        for (int i = 0; i < 8; i++) begin
            en = en_pat[i];
            tick();
        end
        en = 1'b1;
        run(4);
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        run(4);
        check("t5_clr", data0, 32'h0019_7FFF);

        // Reset with samples in flight
        commit(32'h1357_9BDF, 16'h2468, 1'b0);
        run(3);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", 32'(valid0), 32'h0);
        check("t6_rst_data0", data0, 32'h0);
        check("t6_rst_data1", data1, 32'h0);
        reset = 1'b0;
        run(6);

        // Random FTW/POW sweep, ~10k samples
        for (int seg = 0; seg < 10; seg++) begin
            commit($urandom(), 16'($urandom()), 1'(seg & 1));
            for (int i = 0; i < 1000; i++) begin
                en = (seg >= 5) ? ($urandom_range(0, 7) != 0) : 1'b1;
                if (i == 500) begin
                    ftw = $urandom();
                    pow = 16'($urandom());
                end
                cfg_wr    = (i == 500);
                cfg_upd   = (i == 700);
                phase_clr = (i == 300);
                tick();
            end
            cfg_wr = 1'b0; cfg_upd = 1'b0; phase_clr = 1'b0;
        end

        en = 1'b0;
        run(8);
        check("drain", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
